// File: rtl/dma_pkg.sv
// dma_pkg: AXI encodings and read-engine state type shared by the DMA read master
package dma_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARREQ = 2'd1,
        ST_RDATA = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/dma_read_addr_gen.sv
// dma_read_addr_gen: ring-buffer byte offset that advances one burst at a time and wraps inside the region
module dma_read_addr_gen #(
    parameter int ADDR_WIDTH   = 32,
    parameter int BURST_BYTES  = 1024,
    parameter int REGION_BYTES = 8192000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv,
    output logic [ADDR_WIDTH-1:0] offset
);
    logic [ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [63:0] next_off;
    // next offset restarts at zero when the following burst would not fit in the region
    always_comb begin
        next_off = 64'(offset_q) + 64'(BURST_BYTES);
        offset_d = offset_q;
        if (adv) offset_d = (next_off + 64'(BURST_BYTES) > 64'(REGION_BYTES)) ? '0 : next_off[ADDR_WIDTH-1:0];
    end
    // offset register, survives across jobs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) offset_q <= '0;
        else offset_q <= offset_d;
    end
    assign offset = offset_q;
endmodule

// File: rtl/dma_read_m00_axi.sv
// dma_read_m00_axi: AXI4 read master streaming fixed-length bursts from a ring buffer into a FIFO
module dma_read_m00_axi
    import dma_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h10000000,
    parameter int C_M_AXI_READ_BURST_LEN = 256,
    parameter int C_REGION_BYTES = 8192000,
    parameter int C_IRQ_THRESHOLD = 100
) (
    input  logic                          m00_axi_aclk,
    input  logic                          m00_axi_areset,
    input  logic                          start,
    input  logic [31:0]                   num_bursts,
    output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] fifo_din,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    input  logic                          fifo_prog_full,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [31:0]                   bursts_done,
    output logic                          irq
);
    localparam int BURST_BYTES = C_M_AXI_READ_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;
    localparam logic [2:0] ARSIZE = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    state_t state_q, state_d;
    logic arvalid_q, arvalid_d, err_q, err_d, irq_q, irq_d;
    logic [8:0] beat_q, beat_d;
    logic [31:0] remaining_q, remaining_d, bursts_done_q, bursts_done_d, irq_cnt_q, irq_cnt_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] offset;
    logic beat_ok, last_beat, irq_hit, rid_unused;
    assign rid_unused = ^m_axi_rid;
    assign beat_ok = m_axi_rvalid & m_axi_rready;
    assign last_beat = beat_q == 9'(C_M_AXI_READ_BURST_LEN - 1);
    assign irq_hit = irq_cnt_q == 32'(C_IRQ_THRESHOLD - 1);
    dma_read_addr_gen #(
        .ADDR_WIDTH(C_M_AXI_ADDR_WIDTH),
        .BURST_BYTES(BURST_BYTES),
        .REGION_BYTES(C_REGION_BYTES)
    ) u_addr_gen (
        .clk(m00_axi_aclk),
        .rst(m00_axi_areset),
        .adv(beat_ok & last_beat),
        .offset(offset)
    );
    assign m_axi_arid = '0;
    assign m_axi_arlen = 8'(C_M_AXI_READ_BURST_LEN - 1);
    assign m_axi_arsize = ARSIZE;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_araddr = C_M_TARGET_SLAVE_BASE_ADDR + offset;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready = (state_q == ST_RDATA) & ~fifo_full;
    assign fifo_wr_en = beat_ok;
    assign fifo_din = m_axi_rdata;
    assign busy = (state_q == ST_ARREQ) | (state_q == ST_RDATA);
    assign done = state_q == ST_DONE;
    assign err = err_q;
    assign irq = irq_q;
    assign bursts_done = bursts_done_q;
    // job sequencing, address handshake, beat counting, error and irq bookkeeping
    always_comb begin
        state_d = state_q;
        arvalid_d = arvalid_q;
        beat_d = beat_q;
        remaining_d = remaining_q;
        bursts_done_d = bursts_done_q;
        err_d = err_q;
        irq_d = 1'b0;
        irq_cnt_d = irq_cnt_q;
        case (state_q)
            ST_IDLE: if (start) begin
                err_d = 1'b0;
                bursts_done_d = '0;
                irq_cnt_d = '0;
                remaining_d = num_bursts;
                state_d = (num_bursts == '0) ? ST_DONE : ST_ARREQ;
            end
            ST_ARREQ: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    beat_d = '0;
                    state_d = ST_RDATA;
                end else if (!arvalid_q) arvalid_d = ~fifo_prog_full;
            end
            ST_RDATA: if (beat_ok) begin
                beat_d = beat_q + 9'd1;
                if ((m_axi_rlast != last_beat) || (m_axi_rresp != AXI_RESP_OKAY)) err_d = 1'b1;
                if (last_beat) begin
                    beat_d = '0;
                    bursts_done_d = bursts_done_q + 32'd1;
                    remaining_d = remaining_q - 32'd1;
                    irq_cnt_d = irq_hit ? '0 : irq_cnt_q + 32'd1;
                    irq_d = irq_hit;
                    state_d = (remaining_q == 32'd1) ? ST_DONE : ST_ARREQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    // state registers, cleared asynchronously so a burst in flight is dropped at once
    always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
        if (m00_axi_areset) begin
            state_q <= ST_IDLE;
            arvalid_q <= 1'b0;
            beat_q <= '0;
            remaining_q <= '0;
            bursts_done_q <= '0;
            err_q <= 1'b0;
            irq_q <= 1'b0;
            irq_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            arvalid_q <= arvalid_d;
            beat_q <= beat_d;
            remaining_q <= remaining_d;
            bursts_done_q <= bursts_done_d;
            err_q <= err_d;
            irq_q <= irq_d;
            irq_cnt_q <= irq_cnt_d;
        end
    end
endmodule

// File: doc/dma_read_m00_axi.md
DMA_READ_M00_AXI -- requirements
Module: dma_read_m00_axi

Interface
REQ-001 SHALL have parameter C_M_TARGET_SLAVE_BASE_ADDR, default 32'h10000000, first read address.
REQ-002 SHALL have parameter C_M_AXI_READ_BURST_LEN, default 256, beats per burst (1..256).
REQ-003 SHALL have parameters C_M_AXI_ID_WIDTH=1, C_M_AXI_ADDR_WIDTH=32, C_M_AXI_DATA_WIDTH=32, bus widths.
REQ-004 SHALL have parameter C_REGION_BYTES, default 8192000, read-buffer size; offsets wrap at it.
REQ-005 SHALL have parameter C_IRQ_THRESHOLD, default 100, bursts per irq pulse.
REQ-006 m00_axi_aclk  in  1  sole clock; reset is asynchronous and active-high.
REQ-007 m00_axi_areset  in  1  asynchronous active-high reset.
REQ-008 start  in  1  one-cycle pulse; begins a job, ignored while busy.
REQ-009 num_bursts  in  32  bursts in the job, sampled on start; 0 = no bursts.
REQ-010 m_axi_arid/araddr/arlen/arsize/arburst  out  ID/ADDR/8/3/2  AR payload.
REQ-011 m_axi_arvalid out 1, m_axi_arready in 1  AR handshake.
REQ-012 m_axi_rid/rdata/rresp/rlast/rvalid  in  ID/DATA/2/1/1  R payload and valid.
REQ-013 m_axi_rready  out  1  R ready.
REQ-014 fifo_din out DATA, fifo_wr_en out 1, fifo_full in 1, fifo_prog_full in 1  downstream FIFO write side.
REQ-015 busy out 1, done out 1, err out 1, bursts_done out 32, irq out 1  status.

Function
REQ-016 SHALL drive arlen=BURST_LEN-1, arsize=log2(DATA/8), arburst=INCR, arid=0 constantly.
REQ-017 SHALL implement FSM IDLE, ARREQ, RDATA, DONE.
REQ-018 IDLE->ARREQ on start with num_bursts!=0; IDLE->DONE on start with num_bursts==0.
REQ-019 In ARREQ SHALL assert arvalid only when fifo_prog_full=0; once asserted, arvalid and araddr SHALL hold until arready.
REQ-020 ARREQ->RDATA on arvalid&arready; at most one burst outstanding.
REQ-021 m_axi_rready SHALL equal (state==RDATA)&~fifo_full, combinational.
REQ-022 fifo_wr_en SHALL equal rvalid&rready; fifo_din=rdata, same cycle, zero latency.
REQ-023 Beat counter SHALL count accepted beats; burst ends on beat BURST_LEN.
REQ-024 rlast on a beat other than BURST_LEN, rlast missing on beat BURST_LEN, or rresp!=OKAY SHALL set sticky err; burst still ends on beat count.
REQ-025 At burst end: bursts_done+1, offset+=BURST_LEN*DATA/8; offset SHALL reset to 0 when new offset+burst bytes > C_REGION_BYTES.
REQ-026 araddr SHALL equal BASE_ADDR+offset, offset width ADDR_WIDTH, no carry into upper bits.
REQ-027 After burst end: ->ARREQ if bursts remain, else ->DONE.
REQ-028 DONE SHALL pulse done for one cycle then ->IDLE; busy=1 in ARREQ and RDATA.
REQ-029 irq SHALL pulse one cycle each time bursts_done reaches a multiple of C_IRQ_THRESHOLD.
REQ-030 start SHALL clear err and bursts_done; offset persists across jobs (ring buffer).
REQ-031 Simultaneous burst end and irq threshold SHALL both take effect in that cycle.

Reset
REQ-032 On areset: state IDLE, arvalid=0, rready=0, fifo_wr_en=0, busy=0, done=0, err=0, irq=0, bursts_done=0, offset=0, araddr=BASE_ADDR.
REQ-033 Reset mid-burst SHALL abandon the burst immediately; no FIFO writes after reset asserts.

Structure
REQ-034 AXI constants (burst INCR, resp OKAY, state encoding) SHALL live in shared package dma_pkg.
REQ-035 Single module; one optional sub-module dma_read_addr_gen for offset/wrap arithmetic.

Verification
REQ-036 num_bursts=2, slave always ready -> araddr 0x10000000 then 0x10000400, 512 fifo writes, done pulse, bursts_done=2.
REQ-037 fifo_prog_full=1 for 50 cycles after start -> arvalid stays 0, then asserts within 1 cycle of release.
REQ-038 fifo_full toggled every 3 cycles during burst -> rready follows, exactly 256 writes, data order preserved.
REQ-039 C_REGION_BYTES=2048, num_bursts=3 -> addresses 0x10000000, 0x10000400, 0x10000000.
REQ-040 rresp=SLVERR on beat 10, rlast on beat 200 -> err=1, job completes, done pulses.
REQ-041 C_IRQ_THRESHOLD=2, num_bursts=4 -> irq pulses after bursts 2 and 4; reset at beat 100 -> all outputs at reset values.
